ring_cadence_gen: RTL
=====================

// Module: ring_cadence_gen
// PURPOSE
//   Source side of the phone alert path. Accepts an incoming-call request and
//   drives the 'ring' line that the ringer/motor selector consumes.
//   'ring' follows an on/off cadence until the call is answered, rejected, or
//   MAX_RINGS bursts complete. The last case reports a missed call.
// PARAMETERS
//   ON_CYC     4   cycles ring is held high per burst (>=1)
//   OFF_CYC    6   cycles ring is held low between bursts (>=1)
//   MAX_RINGS  3   bursts before the call is declared missed (>=1)
//   CNT_W      8   width of internal timer and ring_count; must hold max(ON_CYC,OFF_CYC,MAX_RINGS)
// PORTS
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   call_valid  in   1      incoming call request (valid/ready handshake)
//   call_ready  out  1      high only in IDLE; handshake = call_valid & call_ready
//   answer      in   1      user answers; honoured only while ringing
//   reject      in   1      user rejects; honoured only while ringing
//   ring        out  1      alert line to ringer/motor selector, registered
//   busy        out  1      high in RING_ON or RING_OFF
//   answered    out  1      1-cycle pulse: call ended by answer
//   missed      out  1      1-cycle pulse: call ended after MAX_RINGS bursts
//   ring_count  out  CNT_W  bursts completed for the current call
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; ring=0, busy=0, answered=0,
//     missed=0, ring_count=0, timer=0; call_ready=1 combinationally from IDLE.
//   FSM states: IDLE, RING_ON, RING_OFF; all outputs are registered except call_ready.
//   IDLE: if call_valid at edge k -> RING_ON at k; ring=1, busy=1 visible after
//     edge k (1-cycle latency from handshake); timer=0, ring_count=0.
//   RING_ON: timer counts 0..ON_CYC-1. At timer==ON_CYC-1: ring_count+=1,
//     timer=0, -> RING_OFF (ring=0 next cycle). ring is high exactly ON_CYC cycles.
//   RING_OFF: timer counts 0..OFF_CYC-1. At timer==OFF_CYC-1:
//     ring_count==MAX_RINGS -> IDLE, missed=1 for one cycle;
//     otherwise -> RING_ON, timer=0.
//   answer in RING_ON/RING_OFF -> IDLE next edge, ring=0, answered=1 one cycle.
//   reject in RING_ON/RING_OFF -> IDLE next edge, ring=0, no pulse.
//   Priority on the same edge: answer > reject > timer expiry.
//     Answer on the final RING_OFF cycle gives answered, not missed.
//   answer/reject in IDLE: ignored.
//   call_valid while busy: ignored (call_ready=0); requester must hold it.
//   ring_count holds its final value in IDLE and clears on the next accept.
//   Back-to-back calls: call_valid high on the cycle after return to IDLE is
//     accepted immediately. No dead cycle beyond the IDLE cycle itself.
//   rst_n low mid-call: ring drops immediately (async); no answered/missed pulse.
//   Timer and ring_count never wrap. CNT_W sizing is the integrator's duty.
// TESTING (defaults ON_CYC=4, OFF_CYC=6, MAX_RINGS=3)
//   Reset: rst_n=0 during clocks -> ring=0, busy=0, call_ready=1, ring_count=0.
//   Missed call: one-cycle call_valid, no user input ->
//     ring high cycles 1-4, 11-14, 21-24 after accept; missed pulse on cycle 31;
//     ring_count=3; call_ready=1 again.
//   Answer: answer pulse on cycle 2 of the 2nd burst -> ring=0 next cycle;
//     answered=1 for 1 cycle; ring_count=1; missed never asserts.
//   Reject, then new call: reject in RING_OFF, then call_valid held high ->
//     no pulses, one IDLE cycle, new call accepted, ring_count cleared to 0.
//   Simultaneous events: answer and reject together on the final RING_OFF cycle
//     of burst 3 -> answered=1, missed=0.
//   Ignored inputs: call_valid held while busy -> call_ready=0, cadence unchanged.
//     rst_n pulled low mid RING_ON -> ring=0 at once, state IDLE.

Source files
------------

// File: rtl/ring_cadence_gen.sv
// Ring cadence generator: accepts an incoming-call request and drives the
// ringer alert line with an on/off cadence. A call ends when it is answered,
// rejected, or after MAX_RINGS complete bursts, which reports a missed call.
module ring_cadence_gen #(
    parameter int ON_CYC    = 4,
    parameter int OFF_CYC   = 6,
    parameter int MAX_RINGS = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             call_valid,
    output logic             call_ready,
    input  logic             answer,
    input  logic             reject,
    output logic             ring,
    output logic             busy,
    output logic             answered,
    output logic             missed,
    output logic [CNT_W-1:0] ring_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RING_ON  = 2'd1,
        RING_OFF = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_RINGS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] next_timer;
    logic [CNT_W-1:0] next_count;
    logic             next_ring;
    logic             next_busy;
    logic             next_answered;
    logic             next_missed;
    logic             stop_req;

    // The user ending the call (answer or reject) outranks timer expiry.
    assign stop_req = answer | reject;

    // Only an idle generator can take a new call.
    assign call_ready = (state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, timer and burst-count selection.
    always_comb begin
        next_state = state;
        next_timer = timer;
        next_count = ring_count;
        case (state)
            IDLE: begin
                if (call_valid) begin
                    next_state = RING_ON;
                    next_timer = '0;
                    next_count = '0;
                end
            end
            RING_ON: begin
                if (stop_req) begin
                    next_state = IDLE;
                    next_timer = '0;
                end else if (timer == ON_LAST) begin
                    next_state = RING_OFF;
                    next_timer = '0;
                    next_count = ring_count + CNT_ONE;
                end else begin
                    next_timer = timer + CNT_ONE;
                end
            end
            RING_OFF: begin
                if (stop_req) begin
                    next_state = IDLE;
                    next_timer = '0;
                end else if (timer == OFF_LAST) begin
                    next_timer = '0;
                    if (ring_count == MAX_COUNT) begin
                        next_state = IDLE;
                    end else begin
                        next_state = RING_ON;
                    end
                end else begin
                    next_timer = timer + CNT_ONE;
                end
            end
            default: begin
                next_state = IDLE;
                next_timer = '0;
            end
        endcase
    end

    // Output values to be registered, derived from the upcoming state.
    always_comb begin
        next_ring     = (next_state == RING_ON);
        next_busy     = (next_state != IDLE);
        next_answered = (state != IDLE) && answer;
        next_missed   = (state == RING_OFF) && !stop_req &&
                        (timer == OFF_LAST) && (ring_count == MAX_COUNT);
    end

    // Registered outputs, timer and burst counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring       <= 1'b0;
            busy       <= 1'b0;
            answered   <= 1'b0;
            missed     <= 1'b0;
            ring_count <= '0;
            timer      <= '0;
        end else begin
            ring       <= next_ring;
            busy       <= next_busy;
            answered   <= next_answered;
            missed     <= next_missed;
            ring_count <= next_count;
            timer      <= next_timer;
        end
    end

endmodule
